// File: rtl/tlb_pkg.sv
// Shared types for the multi-port TLB: entry layout, sweep FSM states, field widths.
package tlb_pkg;

    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int PFN_W  = 20;
    localparam int C_W    = 3;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PFN_W-1:0]  pfn0;
        logic [C_W-1:0]    c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [C_W-1:0]    c1;
        logic              d1;
        logic              v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } inv_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/tlb_mport_if.sv
// Bus bundle for tlb_mport: search ports, TLBWI/TLBWR write, TLBR read, Random/Wired, sweep control.
interface tlb_mport_if
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    parameter  int NSPORT = 2,
    localparam int IDX_W  = clog2(TLBNUM)
) ();

    logic [NSPORT*VPN2_W-1:0] s_vpn2;
    logic [NSPORT-1:0]        s_odd_page;
    logic [NSPORT*ASID_W-1:0] s_asid;
    logic [NSPORT-1:0]        s_found;
    logic [NSPORT*IDX_W-1:0]  s_index;
    logic [NSPORT*PFN_W-1:0]  s_pfn;
    logic [NSPORT*C_W-1:0]    s_c;
    logic [NSPORT-1:0]        s_d;
    logic [NSPORT-1:0]        s_v;
    logic [NSPORT-1:0]        s_multi;

    logic                     we;
    logic [IDX_W-1:0]         w_index;
    logic [VPN2_W-1:0]        w_vpn2;
    logic [ASID_W-1:0]        w_asid;
    logic                     w_g;
    logic [PFN_W-1:0]         w_pfn0;
    logic [C_W-1:0]           w_c0;
    logic                     w_d0;
    logic                     w_v0;
    logic [PFN_W-1:0]         w_pfn1;
    logic [C_W-1:0]           w_c1;
    logic                     w_d1;
    logic                     w_v1;

    logic [IDX_W-1:0]         r_index;
    logic [VPN2_W-1:0]        r_vpn2;
    logic [ASID_W-1:0]        r_asid;
    logic                     r_g;
    logic [PFN_W-1:0]         r_pfn0;
    logic [C_W-1:0]           r_c0;
    logic                     r_d0;
    logic                     r_v0;
    logic [PFN_W-1:0]         r_pfn1;
    logic [C_W-1:0]           r_c1;
    logic                     r_d1;
    logic                     r_v1;

    logic                     wired_we;
    logic [IDX_W-1:0]         wired;
    logic [IDX_W-1:0]         random_index;

    logic                     inv_req;
    logic                     inv_mode;
    logic [ASID_W-1:0]        inv_asid;
    logic                     inv_busy;
    logic                     inv_done;

    modport master (
        output s_vpn2, s_odd_page, s_asid,
        input  s_found, s_index, s_pfn, s_c, s_d, s_v, s_multi,
        output we, w_index, w_vpn2, w_asid, w_g,
        output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        output r_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
        output wired_we, wired,
        input  random_index,
        output inv_req, inv_mode, inv_asid,
        input  inv_busy, inv_done
    );

    modport slave (
        input  s_vpn2, s_odd_page, s_asid,
        output s_found, s_index, s_pfn, s_c, s_d, s_v, s_multi,
        input  we, w_index, w_vpn2, w_asid, w_g,
        input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        input  r_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
        input  wired_we, wired,
        output random_index,
        input  inv_req, inv_mode, inv_asid,
        output inv_busy, inv_done
    );

endinterface

// File: rtl/tlb_match.sv
// One TLB search port: match vector, lowest-index priority encode, multi-hit flag, page select.
// Purely combinational, zero latency.
module tlb_match
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDX_W  = clog2(TLBNUM)
) (
    input  tlb_entry_t        ents [TLBNUM],
    input  logic [VPN2_W-1:0] vpn2,
    input  logic              odd_page,
    input  logic [ASID_W-1:0] asid,
    output logic              found,
    output logic [IDX_W-1:0]  index,
    output logic [PFN_W-1:0]  pfn,
    output logic [C_W-1:0]    c,
    output logic              d,
    output logic              v,
    output logic              multi
);

    localparam logic [TLBNUM-1:0] ONE = TLBNUM'(1);

    logic [TLBNUM-1:0] hit;
    tlb_entry_t        sel;

    always_comb begin
        hit = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            hit[i] = (ents[i].vpn2 == vpn2) && (ents[i].g || (ents[i].asid == asid));
        end
    end

    // Scanning downward leaves the lowest matching index as the final assignment.
    always_comb begin
        index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) index = IDX_W'(i);
        end
    end

    assign sel   = ents[index];
    assign found = |hit;
    assign multi = |(hit & (hit - ONE));

    // The valid bit is reported, not used to qualify the hit; the consumer raises TLB-invalid.
    always_comb begin
        pfn = '0;
        c   = '0;
        d   = 1'b0;
        v   = 1'b0;
        if (found) begin
            if (odd_page) begin
                pfn = sel.pfn1;
                c   = sel.c1;
                d   = sel.d1;
                v   = sel.v1;
            end else begin
                pfn = sel.pfn0;
                c   = sel.c0;
                d   = sel.d0;
                v   = sel.v0;
            end
        end
    end

endmodule

// File: rtl/tlb_mport.sv
// Parametrised MIPS TLB: NSPORT combinational search ports, write/read port, Random/Wired, invalidation sweep.
// Search and read are zero latency; writes land on the next edge; a sweep takes TLBNUM cycles plus a done pulse.
module tlb_mport
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    parameter  int NSPORT = 2,
    localparam int IDX_W  = clog2(TLBNUM)
) (
    input logic        clk,
    input logic        resetn,
    tlb_mport_if.slave bus
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLBNUM - 1);

    tlb_entry_t        ents [TLBNUM];
    tlb_entry_t        w_ent;
    tlb_entry_t        r_ent;

    logic [IDX_W-1:0]  wired_q;
    logic [IDX_W-1:0]  rand_q;

    inv_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q;
    logic              mode_q;
    logic [ASID_W-1:0] asid_q;
    logic              sweep_clr;
    logic              inv_busy;
    logic              inv_done;

    logic [NSPORT-1:0]        s_found, s_d, s_v, s_multi;
    logic [NSPORT*IDX_W-1:0]  s_index;
    logic [NSPORT*PFN_W-1:0]  s_pfn;
    logic [NSPORT*C_W-1:0]    s_c;

    assign w_ent = '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
                     pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
                     pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1};

    // A write to the entry under the sweep pointer takes precedence over the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) ents[i] <= '0;
        end else begin
            for (int i = 0; i < TLBNUM; i++) begin
                if (bus.we && (bus.w_index == IDX_W'(i))) begin
                    ents[i] <= w_ent;
                end else if (sweep_clr && (ptr_q == IDX_W'(i))) begin
                    ents[i].v0 <= 1'b0;
                    ents[i].v1 <= 1'b0;
                end
            end
        end
    end

    assign r_ent       = ents[bus.r_index];
    assign bus.r_vpn2  = r_ent.vpn2;
    assign bus.r_asid  = r_ent.asid;
    assign bus.r_g     = r_ent.g;
    assign bus.r_pfn0  = r_ent.pfn0;
    assign bus.r_c0    = r_ent.c0;
    assign bus.r_d0    = r_ent.d0;
    assign bus.r_v0    = r_ent.v0;
    assign bus.r_pfn1  = r_ent.pfn1;
    assign bus.r_c1    = r_ent.c1;
    assign bus.r_d1    = r_ent.d1;
    assign bus.r_v1    = r_ent.v1;

    for (genvar p = 0; p < NSPORT; p++) begin : g_port
        tlb_match #(.TLBNUM(TLBNUM)) u_match (
            .ents     (ents),
            .vpn2     (bus.s_vpn2[p*VPN2_W +: VPN2_W]),
            .odd_page (bus.s_odd_page[p]),
            .asid     (bus.s_asid[p*ASID_W +: ASID_W]),
            .found    (s_found[p]),
            .index    (s_index[p*IDX_W +: IDX_W]),
            .pfn      (s_pfn[p*PFN_W +: PFN_W]),
            .c        (s_c[p*C_W +: C_W]),
            .d        (s_d[p]),
            .v        (s_v[p]),
            .multi    (s_multi[p])
        );
    end

    assign bus.s_found = s_found;
    assign bus.s_index = s_index;
    assign bus.s_pfn   = s_pfn;
    assign bus.s_c     = s_c;
    assign bus.s_d     = s_d;
    assign bus.s_v     = s_v;
    assign bus.s_multi = s_multi;

    // Random walks down to Wired then wraps to the top; a Wired of TLBNUM-1 pins it there.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wired_q <= '0;
            rand_q  <= MAX_IDX;
        end else if (bus.wired_we) begin
            wired_q <= bus.wired;
            rand_q  <= MAX_IDX;
        end else if ((wired_q == MAX_IDX) || (rand_q == wired_q)) begin
            rand_q  <= MAX_IDX;
        end else begin
            rand_q  <= rand_q - IDX_W'(1);
        end
    end

    assign bus.random_index = rand_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q  <= '0;
            mode_q <= 1'b0;
            asid_q <= '0;
        end else if ((state_q == ST_IDLE) && bus.inv_req) begin
            ptr_q  <= '0;
            mode_q <= bus.inv_mode;
            asid_q <= bus.inv_asid;
        end else if (state_q == ST_SWEEP) begin
            ptr_q  <= ptr_q + IDX_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        inv_busy  = 1'b0;
        inv_done  = 1'b0;
        sweep_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.inv_req) state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                inv_busy  = 1'b1;
                sweep_clr = !mode_q || (!ents[ptr_q].g && (ents[ptr_q].asid == asid_q));
                if (ptr_q == MAX_IDX) state_d = ST_DONE;
            end
            ST_DONE: begin
                inv_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.inv_busy = inv_busy;
    assign bus.inv_done = inv_done;

endmodule

// File: tb/tb_tlb_mport.sv
// Self-checking bench for tlb_mport (TLBNUM=16, NSPORT=4): vector table, corner sequences, random vs. model.
module tb_tlb_mport;
    import tlb_pkg::*;

    localparam int N  = 16;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    tlb_mport_if #(.TLBNUM(N), .NSPORT(NP)) bus ();
    tlb_mport #(.TLBNUM(N), .NSPORT(NP)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference state: entry array, sweep position (-1 = none), done pending, Random by arithmetic.
    tlb_entry_t  m_ent [N];
    int          m_sw;
    bit          m_done;
    bit          m_mode;
    logic [7:0]  m_asid;
    int          rnd_n;
    int          m_wired;

    typedef struct {
        bit          do_wr;
        int          widx;
        tlb_entry_t  wdat;
        logic [18:0] vpn2;
        logic        odd;
        logic [7:0]  asid;
        logic [26:0] exp;   // {found, index, pfn, v, multi}
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                      input logic [19:0] pfn0, input logic v0,
                                      input logic [19:0] pfn1, input logic v1);
        tlb_entry_t e;
        e = '0;
        e.vpn2 = vpn2; e.asid = asid; e.g = g;
        e.pfn0 = pfn0; e.c0 = 3'd2; e.d0 = 1'b1; e.v0 = v0;
        e.pfn1 = pfn1; e.c1 = 3'd3; e.d1 = 1'b0; e.v1 = v1;
        return e;
    endfunction

    function automatic vec_t mkv(input bit do_wr, input int widx, input tlb_entry_t wdat,
                                 input logic [18:0] vpn2, input logic odd, input logic [7:0] asid,
                                 input logic found, input logic [3:0] idx, input logic [19:0] pfn,
                                 input logic v, input logic multi);
        vec_t r;
        r.do_wr = do_wr; r.widx = widx; r.wdat = wdat;
        r.vpn2 = vpn2; r.odd = odd; r.asid = asid;
        r.exp = {found, idx, pfn, v, multi};
        return r;
    endfunction

    function automatic tlb_entry_t cur_wdata();
        tlb_entry_t e;
        e = '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
              pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
              pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1};
        return e;
    endfunction

    function automatic logic [30:0] msearch(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        int q[$];
        tlb_entry_t e;
        for (int i = 0; i < N; i++)
            if (m_ent[i].vpn2 == vpn2 && (m_ent[i].g || m_ent[i].asid == asid)) q.push_back(i);
        if (q.size() == 0) return '0;
        e = m_ent[q[0]];
        if (odd) return {1'b1, 4'(q[0]), e.pfn1, e.c1, e.d1, e.v1, (q.size() > 1)};
        return {1'b1, 4'(q[0]), e.pfn0, e.c0, e.d0, e.v0, (q.size() > 1)};
    endfunction

    function automatic int exp_random();
        if (m_wired >= N - 1) return N - 1;
        return N - 1 - (rnd_n % (N - m_wired));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ent[i] = '0;
        m_sw = -1; m_done = 0; m_mode = 0; m_asid = '0; rnd_n = 0; m_wired = 0;
    endtask

    task automatic drive_idle();
        bus.s_vpn2 = '0; bus.s_odd_page = '0; bus.s_asid = '0;
        bus.we = 0; bus.w_index = '0; bus.w_vpn2 = '0; bus.w_asid = '0; bus.w_g = 0;
        bus.w_pfn0 = '0; bus.w_c0 = '0; bus.w_d0 = 0; bus.w_v0 = 0;
        bus.w_pfn1 = '0; bus.w_c1 = '0; bus.w_d1 = 0; bus.w_v1 = 0;
        bus.r_index = '0; bus.wired_we = 0; bus.wired = '0;
        bus.inv_req = 0; bus.inv_mode = 0; bus.inv_asid = '0;
    endtask

    task automatic set_write(input int idx, input tlb_entry_t e);
        bus.we = 1; bus.w_index = 4'(idx);
        bus.w_vpn2 = e.vpn2; bus.w_asid = e.asid; bus.w_g = e.g;
        bus.w_pfn0 = e.pfn0; bus.w_c0 = e.c0; bus.w_d0 = e.d0; bus.w_v0 = e.v0;
        bus.w_pfn1 = e.pfn1; bus.w_c1 = e.c1; bus.w_d1 = e.d1; bus.w_v1 = e.v1;
    endtask

    task automatic set_search(input int p, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        bus.s_vpn2[p*19 +: 19] = vpn2;
        bus.s_odd_page[p]      = odd;
        bus.s_asid[p*8 +: 8]   = asid;
    endtask

    // Advance the model across the coming rising edge, then move to the next falling edge.
    task automatic tick();
        int  sw_next;
        bit  done_next;
        if (m_sw >= 0 && !(bus.we && int'(bus.w_index) == m_sw)) begin
            if (!m_mode || (!m_ent[m_sw].g && m_ent[m_sw].asid == m_asid)) begin
                m_ent[m_sw].v0 = 1'b0;
                m_ent[m_sw].v1 = 1'b0;
            end
        end
        if (bus.we) m_ent[bus.w_index] = cur_wdata();
        done_next = (m_sw == N - 1);
        sw_next   = -1;
        if (m_sw >= 0) begin
            sw_next = (m_sw == N - 1) ? -1 : m_sw + 1;
        end else if (!m_done && bus.inv_req) begin
            sw_next = 0; m_mode = bus.inv_mode; m_asid = bus.inv_asid;
        end
        m_sw = sw_next; m_done = done_next;
        if (bus.wired_we) begin m_wired = int'(bus.wired); rnd_n = 0; end
        else rnd_n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        model_reset();
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s search p%0d", tag, p),
                {bus.s_found[p], bus.s_index[p*4 +: 4], bus.s_pfn[p*20 +: 20], bus.s_c[p*3 +: 3],
                 bus.s_d[p], bus.s_v[p], bus.s_multi[p]},
                msearch(bus.s_vpn2[p*19 +: 19], bus.s_odd_page[p], bus.s_asid[p*8 +: 8]));
        end
        chk({tag, " read"}, {bus.r_vpn2, bus.r_asid, bus.r_g, bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0,
                             bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1}, m_ent[bus.r_index]);
        chk({tag, " random"}, bus.random_index, exp_random());
        chk({tag, " busy"}, bus.inv_busy, (m_sw >= 0));
        chk({tag, " done"}, bus.inv_done, m_done);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_seq [6];
        int busy_cnt, done_cnt;

        do_reset();
        #1;
        chk("reset random", bus.random_index, 4'd15);
        chk("reset busy", bus.inv_busy, 1'b0);
        chk("reset done", bus.inv_done, 1'b0);
        chk("reset read", {bus.r_vpn2, bus.r_v0, bus.r_v1, bus.r_pfn0}, '0);

        // Vector table: optional write, then the same search on every port.
        vt[0] = mkv(0, 0, '0, 19'h0, 0, 8'h0, 1, 4'd0, 20'h0, 0, 1);
        vt[1] = mkv(1, 3, mk(19'h10, 8'd5, 0, 20'h12345, 1, 20'h0beef, 0), 19'h10, 0, 8'd5, 1, 4'd3, 20'h12345, 1, 0);
        vt[2] = mkv(0, 0, '0, 19'h10, 0, 8'd6, 0, 4'd0, 20'h0, 0, 0);
        vt[3] = mkv(1, 3, mk(19'h10, 8'd5, 1, 20'h12345, 1, 20'h0beef, 0), 19'h10, 0, 8'd6, 1, 4'd3, 20'h12345, 1, 0);
        vt[4] = mkv(1, 9, mk(19'h10, 8'h22, 0, 20'h0abcd, 1, 20'h55555, 0), 19'h10, 0, 8'h22, 1, 4'd3, 20'h12345, 1, 1);
        vt[5] = mkv(0, 0, '0, 19'h10, 1, 8'h22, 1, 4'd3, 20'h0beef, 0, 1);
        vt[6] = mkv(0, 0, '0, 19'h10, 0, 8'h23, 1, 4'd3, 20'h12345, 1, 0);
        vt[7] = mkv(1, 3, mk(19'h11, 8'd5, 0, 20'h12345, 1, 20'h0beef, 0), 19'h10, 0, 8'h22, 1, 4'd9, 20'h0abcd, 1, 0);
        vt[8] = mkv(0, 0, '0, 19'h11, 1, 8'd5, 1, 4'd3, 20'h0beef, 0, 0);
        for (int k = 0; k < 9; k++) begin
            if (vt[k].do_wr) begin
                set_write(vt[k].widx, vt[k].wdat);
                tick();
                bus.we = 0;
            end
            for (int p = 0; p < NP; p++) set_search(p, vt[k].vpn2, vt[k].odd, vt[k].asid);
            #1;
            for (int p = 0; p < NP; p++)
                chk($sformatf("vec%0d p%0d", k, p),
                    {bus.s_found[p], bus.s_index[p*4 +: 4], bus.s_pfn[p*20 +: 20], bus.s_v[p], bus.s_multi[p]},
                    vt[k].exp);
        end

        // A search in the write cycle still sees the old entry.
        set_write(12, mk(19'h30, 8'd1, 1, 20'h33333, 1, 20'h0, 0));
        set_search(0, 19'h30, 0, 8'd1);
        #1;
        chk("same-cycle write old", bus.s_found[0], 1'b0);
        tick();
        bus.we = 0;
        #1;
        chk("after write new", {bus.s_found[0], bus.s_index[3:0]}, 5'h1c);

        // Random walk with Wired = 0, then Wired = 12.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("random w0 step%0d", k), bus.random_index, (k < 16) ? 15 - k : 15);
            tick();
        end
        bus.wired_we = 1; bus.wired = 4'd12;
        tick();
        bus.wired_we = 0;
        exp_seq = '{15, 14, 13, 12, 15, 14};
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("random w12 step%0d", k), bus.random_index, exp_seq[k]);
            tick();
        end

        // ASID-filtered sweep.
        do_reset();
        set_write(1, mk(19'h20, 8'd5, 0, 20'h1, 1, 20'h2, 1)); tick();
        set_write(2, mk(19'h21, 8'd5, 1, 20'h3, 1, 20'h4, 1)); tick();
        set_write(4, mk(19'h22, 8'd7, 0, 20'h5, 1, 20'h6, 1)); tick();
        bus.we = 0;
        bus.inv_req = 1; bus.inv_mode = 1; bus.inv_asid = 8'd5;
        tick();
        bus.inv_req = 0; bus.inv_asid = 8'd0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.inv_busy) busy_cnt++;
            if (bus.inv_done) done_cnt++;
            tick();
        end
        chk("asid sweep busy cycles", busy_cnt, 16);
        chk("asid sweep done pulses", done_cnt, 1);
        bus.r_index = 4'd1; #1; chk("asid sweep idx1 v", {bus.r_v0, bus.r_v1}, 2'b00);
        bus.r_index = 4'd2; #1; chk("asid sweep idx2 v", {bus.r_v0, bus.r_v1}, 2'b11);
        bus.r_index = 4'd4; #1; chk("asid sweep idx4 v", {bus.r_v0, bus.r_v1}, 2'b11);

        // Full sweep colliding with a write to entry 7 in the cycle the sweep reaches it.
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_write(i, mk(19'(i + 64), 8'(i), i[0], 20'(i), 1, 20'(i + 1), 1));
            tick();
        end
        bus.we = 0;
        bus.inv_req = 1; bus.inv_mode = 0;
        tick();
        bus.inv_req = 0;
        for (int k = 0; k < 7; k++) tick();
        set_write(7, mk(19'h77, 8'd1, 0, 20'h77777, 1, 20'h7, 1));
        tick();
        bus.we = 0;
        for (int k = 0; k < 12; k++) tick();
        chk("full sweep idle", bus.inv_busy, 1'b0);
        for (int i = 0; i < N; i++) begin
            bus.r_index = 4'(i);
            #1;
            chk($sformatf("full sweep idx%0d v", i), {bus.r_v0, bus.r_v1}, (i == 7) ? 2'b11 : 2'b00);
        end
        bus.r_index = 4'd7; #1;
        chk("full sweep idx7 pfn0", bus.r_pfn0, 20'h77777);

        // Reset in the middle of a sweep.
        for (int i = 0; i < N; i++) begin
            set_write(i, mk(19'(i), 8'd3, 0, 20'(i), 1, 20'(i), 1));
            tick();
        end
        bus.we = 0;
        bus.inv_req = 1; bus.inv_mode = 0;
        tick();
        bus.inv_req = 0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid sweep busy", bus.inv_busy, 1'b1);
        resetn = 0;
        #1;
        chk("abort busy", bus.inv_busy, 1'b0);
        chk("abort done", bus.inv_done, 1'b0);
        chk("abort random", bus.random_index, 4'd15);
        for (int i = 0; i < N; i++) begin
            bus.r_index = 4'(i);
            #1;
            chk($sformatf("abort idx%0d v", i), {bus.r_v0, bus.r_v1}, 2'b00);
        end
        @(negedge clk);
        resetn = 1;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("abort no done %0d", k), bus.inv_done, 1'b0);
            tick();
        end

        // Randomised traffic against the reference model.
        do_reset();
        for (int it = 0; it < 600; it++) begin
            tlb_entry_t e;
            e = '0;
            e.vpn2 = 19'($urandom_range(0, 3)); e.asid = 8'($urandom_range(0, 3));
            e.g = ($urandom_range(0, 3) == 0);
            e.pfn0 = 20'($urandom); e.c0 = 3'($urandom); e.d0 = 1'($urandom); e.v0 = 1'($urandom);
            e.pfn1 = 20'($urandom); e.c1 = 3'($urandom); e.d1 = 1'($urandom); e.v1 = 1'($urandom);
            set_write($urandom_range(0, N - 1), e);
            bus.we = ($urandom_range(0, 2) == 0);
            for (int p = 0; p < NP; p++)
                set_search(p, 19'($urandom_range(0, 3)), 1'($urandom), 8'($urandom_range(0, 3)));
            bus.r_index  = 4'($urandom);
            bus.inv_req  = ($urandom_range(0, 24) == 0);
            bus.inv_mode = 1'($urandom);
            bus.inv_asid = 8'($urandom_range(0, 3));
            bus.wired_we = ($urandom_range(0, 39) == 0);
            bus.wired    = 4'($urandom);
            #1;
            check_all($sformatf("rnd%0d", it));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
